alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-requester front end for the shared 32-bit combinational ALU. It arbitrates round-robin between two operation requesters, latches the granted operands and op code, and drives the ALU for one cycle, or for MULDIV_CYC cycles on multiply/divide. It captures result and zero flag, then returns them on a single tagged response channel. It sits between the issue logic and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- MULDIV_CYC, 4, cycles the ALU inputs are held stable for MUL/DIV before capture (legal range 1..15)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  32 each  requester 0 operands
- req_sel0  in  4  requester 0 op code
- req_a1, req_b1  in  32 each  requester 1 operands
- req_sel1  in  4  requester 1 op code
- alu_a, alu_b  out  32 each  ALU operand drive
- alu_sel  out  4  ALU op code drive
- alu_res  in  32  ALU result
- alu_zf  in  1  ALU zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that owns the response
- rsp_res  out  32  captured result
- rsp_zf  out  1  captured zero flag
- rsp_err  out  1  illegal op code or divide by zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the round-robin grant picks one requester with a valid request. The pointer favours the requester not granted last. Requester 0 has priority after reset.
  - req_ready is high for the granted requester only (combinational from req_valid and the pointer).
  - On valid&&ready, latch a/b/sel and id, then flip the pointer to the other requester.
- Legal op codes: AND 0000, OR 0001, ADD 0010, NOR 0100, MUL 0101, SUB 0110, XOR 0111, DIV 1000, SLT 1001, GEZ 1011, ZERO 1101, ONES 1110. All others are illegal.
- Illegal op code, or DIV with b==0:
  - skip EXEC and go directly to RESP with rsp_err=1, rsp_res=0, rsp_zf=0;
  - the ALU drive registers are not updated.
- Legal op: go to EXEC. The cycle counter loads MULDIV_CYC-1 for MUL/DIV and 0 otherwise.
- EXEC: alu_a/alu_b/alu_sel come straight from the latched registers.
  - The counter decrements each cycle.
  - When the counter is 0, capture alu_res into rsp_res and alu_zf into rsp_zf, set rsp_err=0, and go to RESP.
- RESP: rsp_valid=1 and rsp_res/zf/err/id are held stable. On rsp_ready, go to IDLE.
- No new request is accepted in EXEC or RESP (req_ready=0). The block holds one operation in flight.
- Both requesters valid on a cycle: only the pointer-favoured one is granted. The loser's req_valid stays asserted and it wins the next IDLE.

## Timing
- Reset values: state IDLE, pointer favours requester 0, req_ready follows grant (0 when no request), alu_a=0, alu_b=0, alu_sel=0000, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_zf=0, rsp_err=0, busy=0.
- Accept at edge T:
  - single-cycle op: EXEC during cycle T+1, rsp_valid first high in cycle T+2;
  - MUL/DIV: rsp_valid first high in cycle T+1+MULDIV_CYC;
  - error path: rsp_valid high in cycle T+1.
- rsp_ready high in the first RESP cycle: IDLE in the next cycle, so a new accept is possible at best every 3 cycles for single-cycle ops.
- The ALU is purely combinational. The capture edge is the last EXEC edge, and the operands are held stable for the whole EXEC window.
- rst_n low at any time: immediate return to reset values. The in-flight operation is dropped and no response is issued.
- MULDIV_CYC=1: MUL/DIV timing identical to single-cycle ops.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit op code localparams above;
  - an is_legal_op function;
  - an is_multicycle_op function (MUL, DIV);
  - the FSM state enum.
- One sub-module: rr_arb2, a 2-way round-robin grant with registered last-grant pointer and an advance input.

## Test plan
- Req 0 only, ADD a=5 b=7 -> accept T, rsp_valid at T+2, rsp_id=0, rsp_res=12, rsp_zf=0, rsp_err=0.
- Req 1 SUB a=9 b=9 with MULDIV_CYC=4 baseline -> rsp_res=0, rsp_zf=1, rsp_valid at T+2. Then MUL a=3 b=4 -> rsp_res=12 at T+5, alu inputs stable for 4 cycles.
- Both requesters held valid continuously with ADD -> grants alternate 0,1,0,1. After reset, the first grant goes to 0.
- DIV a=10 b=0 -> rsp_valid at T+1, rsp_err=1, rsp_res=0, no change on alu_*. Op code 0011 -> same error response.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout, busy=1. Release -> IDLE the next cycle.
- rst_n pulsed low mid-EXEC of a DIV -> all outputs at reset values asynchronously, no rsp_valid afterwards. The next request is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request front end: op codes, op classification
// helpers and the sequencing state type.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_GEZ  = 4'b1011;
  localparam logic [3:0] OP_ZERO = 4'b1101;
  localparam logic [3:0] OP_ONES = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] sel);
    logic ok;
    case (sel)
      OP_AND, OP_OR, OP_ADD, OP_NOR, OP_MUL, OP_SUB,
      OP_XOR, OP_DIV, OP_SLT, OP_GEZ, OP_ZERO, OP_ONES: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_multicycle_op(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant; the registered pointer favours the requester that
// was not granted on the last advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    if (!ptr) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= ~gnt[1];
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end for the shared combinational ALU: accepts one request,
// holds the ALU inputs for the op's duration, returns a tagged response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [3:0]  req_sel0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [3:0]  req_sel1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_res,
  input  logic        alu_zf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_res,
  output logic        rsp_zf,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] MC_LOAD = 4'(MULDIV_CYC - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  gnt;
  logic        accept;
  logic        gid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_sel;
  logic        bad_op;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    gid    = gnt[1];
    in_a   = gid ? req_a1   : req_a0;
    in_b   = gid ? req_b1   : req_b0;
    in_sel = gid ? req_sel1 : req_sel0;
    bad_op = !is_legal_op(in_sel) || ((in_sel == OP_DIV) && (in_b == '0));
  end

  // The ALU drive registers double as the operand latch, so a rejected op
  // leaves the ALU inputs exactly as the previous operation left them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_zf    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_id <= gid;
            busy   <= 1'b1;
            if (bad_op) begin
              rsp_res   <= '0;
              rsp_zf    <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_a   <= in_a;
              alu_b   <= in_b;
              alu_sel <= in_sel;
              cnt     <= is_multicycle_op(in_sel) ? MC_LOAD : 4'd0;
              state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_res   <= alu_res;
            rsp_zf    <= alu_zf;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter with a behavioural ALU and
// an arbitration/latency reference model.
module tb_alu_req_arbiter;

  localparam int MC = 4;
  localparam logic [3:0] S_ADD = 4'b0010, S_MUL = 4'b0101, S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0111, S_DIV = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_sel0, req_sel1;
  logic [31:0] alu_a, alu_b, alu_res, rsp_res;
  logic [3:0]  alu_sel;
  logic        alu_zf, rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_err, busy;

  int   vectors = 0;
  int   miscompares = 0;
  logic fav = 1'b0;

  alu_req_arbiter #(.MULDIV_CYC(MC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zf(rsp_zf), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd4:  return ~(a | b);
      4'd5:  return a * b;
      4'd6:  return a - b;
      4'd7:  return a ^ b;
      4'd8:  return (b == 0) ? 32'd0 : a / b;
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: return ($signed(a) >= 0) ? 32'd1 : 32'd0;
      4'd13: return 32'd0;
      4'd14: return 32'hFFFF_FFFF;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_res = alu_fn(alu_sel, alu_a, alu_b);
    alu_zf  = (alu_res == 32'd0);
  end

  // Expected response and accept-to-rsp_valid latency for one operation.
  function automatic void model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic zf, output logic err, output int lat);
    logic legal;
    legal = s inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd13, 4'd14};
    err   = !legal || (s == S_DIV && b == 0);
    res   = err ? 32'd0 : alu_fn(s, a, b);
    zf    = err ? 1'b0 : (res == 32'd0);
    lat   = err ? 1 : ((s == S_MUL || s == S_DIV) ? 1 + MC : 2);
  endfunction

  // Drives one transaction and reports what was observed; gnt=0 / lat=-1 on timeout.
  task automatic issue(input logic [1:0] mask,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1,
                       input int stall,
                       output logic [1:0] gnt, output int lat, output logic [31:0] res,
                       output logic zf, output logic err, output logic rid, output int exec_n,
                       output logic stable, output logic stall_ok, output logic idle_after);
    logic [67:0] first_drive;
    logic        first;
    req_a0 = a0; req_b0 = b0; req_sel0 = s0;
    req_a1 = a1; req_b1 = b1; req_sel1 = s1;
    req_valid = mask;
    gnt = '0; lat = -1; res = '0; zf = 0; err = 0; rid = 0;
    exec_n = 0; stable = 1; stall_ok = 0; idle_after = 0;
    first_drive = '0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (|req_ready) begin gnt = req_ready; break; end
      @(negedge clk);
    end
    if (gnt == 2'b00) begin req_valid = '0; return; end
    @(posedge clk); #1;
    req_valid = req_valid & ~gnt;
    first = 1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
      if (busy) begin
        exec_n++;
        if (first) begin first_drive = {alu_a, alu_b, alu_sel}; first = 0; end
        else if ({alu_a, alu_b, alu_sel} !== first_drive) stable = 0;
      end
    end
    if (lat < 0) return;
    res = rsp_res; zf = rsp_zf; err = rsp_err; rid = rsp_id;
    stall_ok = 1;
    for (int i = 0; i < stall; i++) begin
      if (rsp_valid !== 1 || busy !== 1 || req_ready !== 2'b00 ||
          {rsp_res, rsp_zf, rsp_err, rsp_id} !== {res, zf, err, rid}) stall_ok = 0;
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    idle_after = (busy === 1'b0) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 0; req_valid = '0; rsp_ready = 0;
    req_a0 = '0; req_b0 = '0; req_sel0 = '0; req_a1 = '0; req_b1 = '0; req_sel1 = '0;
    #12;
    vectors++;
    if ({busy, rsp_valid, rsp_id, rsp_zf, rsp_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 00000", {busy, rsp_valid, rsp_id, rsp_zf, rsp_err});
    end
    vectors++;
    if ({alu_a, alu_b, alu_sel, rsp_res} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h/%h/%h/%h want 0", alu_a, alu_b, alu_sel, rsp_res);
    end
    vectors++;
    if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready_idle got %b want 00", req_ready); end
    req_valid = 2'b10; #1;
    vectors++;
    if (req_ready !== 2'b10) begin miscompares++; $display("FAIL reset_ready_r1 got %b want 10", req_ready); end
    req_valid = 2'b11; #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL reset_ready_both got %b want 01", req_ready); end
    req_valid = '0;
    @(negedge clk); rst_n = 1; fav = 0;
  endtask

  task automatic test_add;
    logic [1:0] g; int lat, en; logic [31:0] r; logic zf, er, id, st, so, ia;
    issue(2'b01, 32'd5, 32'd7, S_ADD, '0, '0, '0, 0, g, lat, r, zf, er, id, en, st, so, ia);
    fav = 1;
    vectors++;
    if (g !== 2'b01 || lat != 2) begin miscompares++; $display("FAIL add_timing got gnt=%b lat=%0d want gnt=01 lat=2", g, lat); end
    vectors++;
    if ({id, r, zf, er} !== {1'b0, 32'd12, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL add_rsp got id=%b res=%0d zf=%b err=%b want 0/12/0/0", id, r, zf, er);
    end
    vectors++;
    if (en != 1 || ia !== 1'b1) begin miscompares++; $display("FAIL add_exec got exec=%0d idle=%b want 1/1", en, ia); end
  endtask

  task automatic test_sub_mul;
    logic [1:0] g; int lat, en; logic [31:0] r; logic zf, er, id, st, so, ia;
    issue(2'b10, '0, '0, '0, 32'd9, 32'd9, S_SUB, 0, g, lat, r, zf, er, id, en, st, so, ia);
    fav = 0;
    vectors++;
    if (g !== 2'b10 || lat != 2 || {id, r, zf, er} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL sub_rsp got gnt=%b lat=%0d id=%b res=%0d zf=%b err=%b want 10/2/1/0/1/0", g, lat, id, r, zf, er);
    end
    issue(2'b10, '0, '0, '0, 32'd3, 32'd4, S_MUL, 0, g, lat, r, zf, er, id, en, st, so, ia);
    fav = 0;
    vectors++;
    if (lat != 1 + MC || r !== 32'd12 || id !== 1'b1) begin
      miscompares++; $display("FAIL mul_rsp got lat=%0d res=%0d id=%b want %0d/12/1", lat, r, id, 1 + MC);
    end
    vectors++;
    if (en != MC || st !== 1'b1 || {alu_a, alu_b, alu_sel} !== {32'd3, 32'd4, S_MUL}) begin
      miscompares++; $display("FAIL mul_hold got exec=%0d stable=%b sel=%h want %0d/1/%h", en, st, alu_sel, MC, S_MUL);
    end
  endtask

  task automatic test_alternate;
    logic [1:0] g; int lat, en; logic [31:0] r; logic zf, er, id, st, so, ia;
    logic w;
    @(negedge clk); rst_n = 0; #2; rst_n = 1; fav = 0;
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, 32'd100 + 32'(i), 32'd1, S_ADD, 32'd200 + 32'(i), 32'd2, S_ADD, 0,
            g, lat, r, zf, er, id, en, st, so, ia);
      w = fav; fav = ~w;
      vectors++;
      if (g !== (w ? 2'b10 : 2'b01) || id !== w ||
          r !== (w ? 32'd202 + 32'(i) : 32'd101 + 32'(i))) begin
        miscompares++; $display("FAIL alternate[%0d] got gnt=%b id=%b res=%0d want id=%b", i, g, id, r, w);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_errors;
    logic [1:0] g; int lat, en; logic [31:0] r; logic zf, er, id, st, so, ia;
    logic [67:0] pre;
    pre = {alu_a, alu_b, alu_sel};
    issue(2'b01, 32'd10, 32'd0, S_DIV, '0, '0, '0, 0, g, lat, r, zf, er, id, en, st, so, ia);
    fav = 1;
    vectors++;
    if (lat != 1 || en != 0 || {id, r, zf, er} !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL div0_rsp got lat=%0d exec=%0d id=%b res=%0d zf=%b err=%b want 1/0/0/0/0/1", lat, en, id, r, zf, er);
    end
    vectors++;
    if ({alu_a, alu_b, alu_sel} !== pre) begin miscompares++; $display("FAIL div0_alu got %h want %h", {alu_a, alu_b, alu_sel}, pre); end
    issue(2'b10, '0, '0, '0, 32'd1, 32'd2, 4'b0011, 0, g, lat, r, zf, er, id, en, st, so, ia);
    fav = 0;
    vectors++;
    if (lat != 1 || {id, r, zf, er} !== {1'b1, 32'd0, 1'b0, 1'b1} || {alu_a, alu_b, alu_sel} !== pre) begin
      miscompares++; $display("FAIL illegal_op got lat=%0d id=%b res=%0d err=%b alu=%h want 1/1/0/1/%h", lat, id, r, er, {alu_a, alu_b, alu_sel}, pre);
    end
  endtask

  task automatic test_stall;
    logic [1:0] g; int lat, en; logic [31:0] r, er_res; logic zf, er, id, st, so, ia;
    logic ezf, eer; int elat;
    model(S_XOR, 32'h1234_5678, 32'h0F0F_0F0F, er_res, ezf, eer, elat);
    issue(2'b11, 32'h1234_5678, 32'h0F0F_0F0F, S_XOR, 32'h1234_5678, 32'h0F0F_0F0F, S_XOR, 5,
          g, lat, r, zf, er, id, en, st, so, ia);
    req_valid = '0;
    vectors++;
    if (id !== fav || r !== er_res || lat != elat) begin
      miscompares++; $display("FAIL stall_rsp got id=%b res=%h lat=%0d want %b/%h/%0d", id, r, lat, fav, er_res, elat);
    end
    fav = ~fav;
    vectors++;
    if (so !== 1'b1 || ia !== 1'b1) begin miscompares++; $display("FAIL stall_hold got stable=%b idle=%b want 1/1", so, ia); end
  endtask

  task automatic test_reset_mid_exec;
    logic [1:0] g; int lat, en; logic [31:0] r; logic zf, er, id, st, so, ia;
    logic seen, got;
    req_a0 = 32'd100; req_b0 = 32'd7; req_sel0 = S_DIV; req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1; if (req_ready[0]) begin got = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); #2;
    vectors++;
    if (!got || busy !== 1'b1 || alu_a !== 32'd100) begin
      miscompares++; $display("FAIL rst_pre got accepted=%b busy=%b alu_a=%0d want 1/1/100", got, busy, alu_a);
    end
    rst_n = 0; #1;
    vectors++;
    if ({busy, rsp_valid, rsp_id, rsp_zf, rsp_err, req_ready} !== 7'b0 || {alu_a, alu_b, alu_sel, rsp_res} !== '0) begin
      miscompares++; $display("FAIL rst_async got busy=%b alu_a=%0d sel=%h res=%0d want 0", busy, alu_a, alu_sel, rsp_res);
    end
    @(negedge clk); rst_n = 1; fav = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1; end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL rst_dropped got rsp_valid=1 want 0"); end
    issue(2'b11, 32'd40, 32'd2, S_ADD, 32'd50, 32'd3, S_SUB, 0, g, lat, r, zf, er, id, en, st, so, ia);
    req_valid = '0; fav = 1;
    vectors++;
    if (g !== 2'b01 || lat != 2 || {id, r, er} !== {1'b0, 32'd42, 1'b0}) begin
      miscompares++; $display("FAIL rst_recover got gnt=%b lat=%0d id=%b res=%0d want 01/2/0/42", g, lat, id, r);
    end
  endtask

  task automatic test_random;
    logic [1:0] g, mask; int lat, en, elat; logic [31:0] r, eres; logic zf, er, id, st, so, ia, ezf, eer, w;
    logic [31:0] a[2], b[2]; logic [3:0] s[2];
    for (int n = 0; n < 40; n++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        a[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
        b[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
        s[k] = 4'($urandom_range(0, 15));
        if (s[k] == S_DIV && $urandom_range(0, 1) == 0) b[k] = '0;
      end
      w = (mask == 2'b11) ? fav : mask[1];
      model(s[w], a[w], b[w], eres, ezf, eer, elat);
      issue(mask, a[0], b[0], s[0], a[1], b[1], s[1], int'($urandom_range(0, 2)),
            g, lat, r, zf, er, id, en, st, so, ia);
      req_valid = '0;
      fav = ~w;
      vectors++;
      if (g !== (w ? 2'b10 : 2'b01) || id !== w || lat != elat) begin
        miscompares++; $display("FAIL rand[%0d]_arb got gnt=%b id=%b lat=%0d want id=%b lat=%0d", n, g, id, lat, w, elat);
      end
      vectors++;
      if ({r, zf, er} !== {eres, ezf, eer} || st !== 1'b1) begin
        miscompares++; $display("FAIL rand[%0d]_rsp sel=%h got res=%h zf=%b err=%b stable=%b want %h/%b/%b/1", n, s[w], r, zf, er, st, eres, ezf, eer);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_mul;
    test_alternate;
    test_errors;
    test_stall;
    test_reset_mid_exec;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
